ram_fifo_ctrl: RTL
==================

# ram_fifo_ctrl

FIFO controller that sits directly upstream of the single-port `RAM` block and drives its `WrEn`, `RdEn`, `Address` and `WrData` inputs, consuming `RdData`. It turns the address-based RAM into a first-in-first-out queue.
- Producer side: valid/ready push interface.
- Consumer side: valid/ready pop interface, backed by a one-entry output register.
- Arbitration: one RAM access per cycle, because the RAM has a single port.

## Interface
- `ADDR_WIDTH`, 4: RAM address width; must match the attached RAM.
- `MEMORY_DEPTH`, 8: number of RAM words used. Range 2 .. 2^ADDR_WIDTH; need not be a power of two.
- `MEM_WIDTH`, 16: data word width.

- `Clk`  in  1  sole clock; all state updates on the rising edge.
- `Rst`  in  1  reset; synchronous, active-high.
- `InValid`  in  1  producer offers `InData`.
- `InReady`  out  1  controller accepts `InData` this cycle.
- `InData`  in  MEM_WIDTH  push data.
- `OutValid`  out  1  `OutData` holds the oldest word.
- `OutReady`  in  1  consumer takes `OutData` this cycle.
- `OutData`  out  MEM_WIDTH  pop data.
- `WrEn`  out  1  to RAM.
- `RdEn`  out  1  to RAM.
- `Address`  out  ADDR_WIDTH  to RAM.
- `WrData`  out  MEM_WIDTH  to RAM.
- `RdData`  in  MEM_WIDTH  from RAM; valid on the cycle after `RdEn` is sampled.
- `Count`  out  ADDR_WIDTH+1  total words held, i.e. RAM entries + `OutValid`.
- `Full`  out  1  RAM holds `MEMORY_DEPTH` entries.
- `Empty`  out  1  `Count == 0`.

## Operation
- Internal state:
  - `wr_ptr` and `rd_ptr`, each 0..MEMORY_DEPTH-1; they wrap from MEMORY_DEPTH-1 to 0.
  - `ram_cnt`, 0..MEMORY_DEPTH.
  - The output register.
  - A 2-state FSM: `S_IDLE` and `S_RD`.
- `pop` is `OutValid && OutReady`.
- `need_fetch` is `(ram_cnt != 0) && (!OutValid || pop)` while in `S_IDLE`.
- `S_IDLE`:
  - If `need_fetch`:
    - Drive `RdEn=1`, `Address=rd_ptr`, `InReady=0`.
    - On the next edge: go to `S_RD`, `rd_ptr++`, `ram_cnt--`.
    - Read has priority over write.
  - Otherwise:
    - `InReady = !Full`.
    - If `InValid && InReady`: drive `WrEn=1`, `Address=wr_ptr`, `WrData=InData`.
    - On the next edge: `wr_ptr++`, `ram_cnt++`.
- `S_RD`:
  - The RAM port is free, so `InReady = !Full` and a write may be issued exactly as in `S_IDLE`.
  - On the next edge: `OutData <= RdData`, `OutValid <= 1`, return to `S_IDLE`.
- A pop clears `OutValid` on the next edge unless a capture happens on that same edge.
- `OutValid` is always 0 during `S_RD`, because a fetch is only issued when the output register empties.
- When neither a read nor a write is issued: `WrEn=RdEn=0`, `Address=0`, `WrData=0`.
- `WrEn` and `RdEn` are never both 1.
- Simultaneous events:
  - Write and pop in the same cycle are both honoured.
  - Write and capture in the same `S_RD` cycle are both honoured.
  - `ram_cnt` changes by the net amount.
- Full: `InReady=0` and no write is issued. Total capacity is MEMORY_DEPTH+1 words, counting the output register.
- Empty RAM: no read is issued. `OutValid` drops after the last pop.

## Timing
- RAM-side outputs and `InReady` are combinational from registered state and inputs; `InReady` does not depend on `InValid`.
- Push to `OutValid`, starting from an empty controller: 3 cycles.
  - Cycle 0: write.
  - Cycle 1: read.
  - Edge ending cycle 2: capture.
- Read-side throughput while draining is 1 word per 2 cycles. Write-side throughput is 1 word per cycle whenever no fetch is pending.
- Reset:
  - While `Rst=1`: `InReady=0`, `WrEn=RdEn=0`.
  - On the reset edge: pointers, `ram_cnt`, FSM (to `S_IDLE`), `OutValid` and `OutData` all go to 0.
  - The cycle after reset: `Count=0`, `Empty=1`, `Full=0`, `InReady=1`.
  - Reset mid-operation, including in `S_RD`, discards all data; the in-flight `RdData` is ignored.

## Configuration
- `RAM_FIFO_AFULL_EN`:
  - Defined: adds output port `AlmostFull`, width 1, equal to `ram_cnt >= MEMORY_DEPTH-1`; it resets to 0.
  - Undefined: the port and its logic are absent; all other behaviour is identical.

## Test plan
- Reset: hold `Rst=1` for 2 cycles with `InValid=1` → `InReady=0`, `WrEn=RdEn=0`, `Address=0`, `Count=0`, `Empty=1`. The cycle after release, `InReady=1`.
- Push 5, 10, 25 with `OutReady=0` → exact sequence:
  - Write 5 @0.
  - Read @0 with `InReady=0`.
  - Write 10 @1 while `OutData` becomes 5.
  - Write 25 @2.
  - End state: `Count=3`, `OutValid=1`, `OutData=5`.
- Fill: push 1..9 with `OutReady=0` → `OutData=1`, `Count=9`, `Full=1`, `InReady=0`. A 10th word offered is held off until a pop. With `RAM_FIFO_AFULL_EN`, `AlmostFull=1` from `Count=8`.
- Drain: after the fill, `OutReady=1` → pops 1..9 in order, one every 2 cycles; then `Empty=1` and `OutValid=0`.
- Wrap and concurrency: stream 20 words 0x100..0x113 with `OutReady=1` throughout → `Address` wraps 7→0 on both pointers, output order is preserved, no word is lost or duplicated, and `WrEn&&RdEn` is never 1.
- Mid-operation reset: 3 words stored, assert `Rst` during `S_RD` → next cycle `Count=0`, `OutValid=0`. A subsequent push of 0xAAAA is written @0 and popped as 0xAAAA.

Source files
------------

// File: rtl/ram_fifo_ctrl.sv
// FIFO controller that turns a single-port RAM into a queue with a one-word output register.
// Optional feature macro: RAM_FIFO_AFULL_EN adds the AlmostFull output.
module ram_fifo_ctrl #(
    parameter int ADDR_WIDTH   = 4,
    parameter int MEMORY_DEPTH = 8,
    parameter int MEM_WIDTH    = 16
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic                  InValid,
    output logic                  InReady,
    input  logic [MEM_WIDTH-1:0]  InData,
    output logic                  OutValid,
    input  logic                  OutReady,
    output logic [MEM_WIDTH-1:0]  OutData,
    output logic                  WrEn,
    output logic                  RdEn,
    output logic [ADDR_WIDTH-1:0] Address,
    output logic [MEM_WIDTH-1:0]  WrData,
    input  logic [MEM_WIDTH-1:0]  RdData,
    output logic [ADDR_WIDTH:0]   Count,
    output logic                  Full,
    output logic                  Empty
`ifdef RAM_FIFO_AFULL_EN
    ,
    output logic                  AlmostFull
`endif
);

    localparam int CW = ADDR_WIDTH + 1;
    localparam logic [ADDR_WIDTH-1:0] LAST_PTR  = ADDR_WIDTH'(MEMORY_DEPTH - 1);
    localparam logic [CW-1:0]         DEPTH_CNT = CW'(MEMORY_DEPTH);

    typedef enum logic {S_IDLE, S_RD} state_t;

    state_t                state_q,    state_d;
    logic [ADDR_WIDTH-1:0] wr_ptr_q,   wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q,   rd_ptr_d;
    logic [CW-1:0]         ram_cnt_q,  ram_cnt_d;
    logic                  out_valid_q, out_valid_d;
    logic [MEM_WIDTH-1:0]  out_data_q, out_data_d;

    logic pop;
    logic full;
    logic need_fetch;
    logic do_rd;
    logic do_wr;
    logic in_ready;

    function automatic logic [ADDR_WIDTH-1:0] next_ptr(input logic [ADDR_WIDTH-1:0] p);
        next_ptr = (p == LAST_PTR) ? '0 : p + ADDR_WIDTH'(1);
    endfunction

    always_comb begin
        pop        = out_valid_q && OutReady;
        full       = (ram_cnt_q == DEPTH_CNT);
        // Refill the output register as soon as it is (or is about to become) empty.
        need_fetch = (state_q == S_IDLE) && (ram_cnt_q != '0) && (!out_valid_q || pop);
        do_rd      = need_fetch && !Rst;
        in_ready   = !Rst && !need_fetch && !full;
        do_wr      = InValid && in_ready;

        WrEn    = do_wr;
        RdEn    = do_rd;
        Address = '0;
        WrData  = '0;
        if (do_rd) begin
            Address = rd_ptr_q;
        end else if (do_wr) begin
            Address = wr_ptr_q;
            WrData  = InData;
        end

        wr_ptr_d  = do_wr ? next_ptr(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d  = do_rd ? next_ptr(rd_ptr_q) : rd_ptr_q;
        ram_cnt_d = ram_cnt_q;
        if (do_wr) begin
            ram_cnt_d = ram_cnt_q + CW'(1);
        end else if (do_rd) begin
            ram_cnt_d = ram_cnt_q - CW'(1);
        end

        state_d     = state_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        case (state_q)
            S_IDLE: begin
                if (do_rd) begin
                    state_d = S_RD;
                end
                if (pop) begin
                    out_valid_d = 1'b0;
                end
            end
            S_RD: begin
                // RdData answers the read issued in the previous cycle.
                state_d     = S_IDLE;
                out_valid_d = 1'b1;
                out_data_d  = RdData;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q     <= S_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            ram_cnt_q   <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            ram_cnt_q   <= ram_cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign InReady  = in_ready;
    assign OutValid = out_valid_q;
    assign OutData  = out_data_q;
    assign Count    = ram_cnt_q + CW'(out_valid_q);
    assign Full     = full;
    assign Empty    = (ram_cnt_q == '0) && !out_valid_q;

`ifdef RAM_FIFO_AFULL_EN
    assign AlmostFull = (ram_cnt_q >= CW'(MEMORY_DEPTH - 1));
`endif

endmodule
